muldiv_execution_unit: RTL

Parametrised multi-cycle execution unit for the RV32M ops.
- Pipelined multiplier with configurable stage count.
- Iterative radix-2 divider for DIV/DIVU/REM/REMU.
- Registered, stall-able CDB output with flush support.
- Sits beside the single-cycle ALU unit: takes INSTR_READY_ENTRY from the RS, returns EX_WR_PACKET to the CDB arbiter.

---
 rtl/muldiv_execution_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_execution_unit.sv
// muldiv_execution_unit: RV32M multiply/divide execution unit with a registered, stall-able CDB output.
// Ports: clock_i/reset_i (sync, active-high); issue_*_i = RS entry (ready, func, rs1/rs2 values, rd_tag, npc, inst, spec);
//        flush_i kills all in-flight ops; cdb_grant_i accepts ex_*_o; mul_ready_o/div_ready_o = op class acceptable;
//        ex_*_o = result packet (valid, value, rob_tag, npc, inst, spec); busy_o = anything in flight or ex valid.
module muldiv_execution_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 3,
    parameter int DIV_ENABLE = 1,
    parameter int TAG_W      = 6
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             issue_ready_i,
    input  logic [3:0]       issue_func_i,
    input  logic [XLEN-1:0]  issue_rs1_value_i,
    input  logic [XLEN-1:0]  issue_rs2_value_i,
    input  logic [TAG_W-1:0] issue_rd_tag_i,
    input  logic [XLEN-1:0]  issue_npc_i,
    input  logic [31:0]      issue_inst_i,
    input  logic             issue_spec_i,
    input  logic             flush_i,
    input  logic             cdb_grant_i,
    output logic             mul_ready_o,
    output logic             div_ready_o,
    output logic             ex_valid_o,
    output logic [XLEN-1:0]  ex_value_o,
    output logic [TAG_W-1:0] ex_rob_tag_o,
    output logic [XLEN-1:0]  ex_npc_o,
    output logic [31:0]      ex_inst_o,
    output logic             ex_spec_o,
    output logic             busy_o
);
    localparam int CW = $clog2(XLEN);
    typedef struct packed {
        logic [XLEN-1:0]  value;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  npc;
        logic [31:0]      inst;
        logic             spec;
    } res_t;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_st_t;
    div_st_t          st_q, st_d;
    res_t             ex_q, mul_in, mul_last, div_q, div_d;
    logic             ex_valid_q, stall, mul_acc, div_acc, mul_last_v, mul_busy;
    logic             a_sx, b_sx, sgn, is_rem, a_neg, b_neg;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]  a_mag, b_mag, rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, r_nx, q_nx;
    logic [XLEN:0]    r_sh;
    logic             ge, nq_q, nq_d, nr_q, nr_d, isr_q, isr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    assign stall       = ex_valid_q & ~cdb_grant_i;
    assign mul_ready_o = ~stall & (st_q == IDLE);
    assign div_ready_o = (DIV_ENABLE != 0) & ~stall & (st_q == IDLE) & ~mul_busy;
    assign mul_acc     = issue_ready_i & (issue_func_i[3:2] == 2'b10) & mul_ready_o & ~flush_i;
    assign div_acc     = issue_ready_i & (issue_func_i[3:2] == 2'b11) & div_ready_o & ~flush_i;
    assign busy_o      = mul_busy | (st_q != IDLE) | ex_valid_q;
    // Multiplier: both operands sign/zero-extended to 2*XLEN, so one unsigned product covers all four ops.
    assign a_sx = (issue_func_i[1:0] == 2'b01) | (issue_func_i[1:0] == 2'b10);
    assign b_sx = issue_func_i[1:0] == 2'b01;
    assign prod = {{XLEN{a_sx & issue_rs1_value_i[XLEN-1]}}, issue_rs1_value_i}
                * {{XLEN{b_sx & issue_rs2_value_i[XLEN-1]}}, issue_rs2_value_i};
    assign mul_in = {(issue_func_i[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN],
                     issue_rd_tag_i, issue_npc_i, issue_inst_i, issue_spec_i};
    generate
        if (MUL_STAGES == 1) begin : g_comb
            assign mul_last   = mul_in;
            assign mul_last_v = mul_acc;
            assign mul_busy   = 1'b0;
        end else begin : g_pipe
            // MUL_STAGES-1 registers; the output register supplies the final stage.
            res_t p_q  [MUL_STAGES-1];
            logic pv_q [MUL_STAGES-1];
            always_ff @(posedge clock_i) begin
                if (reset_i || flush_i) begin
                    for (int k = 0; k < MUL_STAGES-1; k++) pv_q[k] <= 1'b0;
                end else if (!stall) begin
                    pv_q[0] <= mul_acc;
                    p_q[0]  <= mul_in;
                    for (int k = 1; k < MUL_STAGES-1; k++) begin
                        pv_q[k] <= pv_q[k-1];
                        p_q[k]  <= p_q[k-1];
                    end
                end
            end
            always_comb begin
                mul_busy = 1'b0;
                for (int k = 0; k < MUL_STAGES-1; k++) mul_busy = mul_busy | pv_q[k];
            end
            assign mul_last   = p_q[MUL_STAGES-2];
            assign mul_last_v = pv_q[MUL_STAGES-2];
        end
    endgenerate
    // Divider: restoring radix-2 on magnitudes; signs reapplied when the last quotient bit lands.
    assign sgn    = ~issue_func_i[0];
    assign is_rem = issue_func_i[1];
    assign a_neg  = sgn & issue_rs1_value_i[XLEN-1];
    assign b_neg  = sgn & issue_rs2_value_i[XLEN-1];
    assign a_mag  = a_neg ? -issue_rs1_value_i : issue_rs1_value_i;
    assign b_mag  = b_neg ? -issue_rs2_value_i : issue_rs2_value_i;
    assign r_sh   = {rem_q, quo_q[XLEN-1]};
    assign ge     = r_sh >= {1'b0, dvs_q};
    assign r_nx   = ge ? r_sh[XLEN-1:0] - dvs_q : r_sh[XLEN-1:0];
    assign q_nx   = {quo_q[XLEN-2:0], ge};
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        nq_d  = nq_q;
        nr_d  = nr_q;
        isr_d = isr_q;
        div_d = div_q;
        if (st_q == IDLE && div_acc) begin
            div_d = {a_mag, issue_rd_tag_i, issue_npc_i, issue_inst_i, issue_spec_i};
            cnt_d = '0;
            rem_d = '0;
            quo_d = a_mag;
            dvs_d = b_mag;
            nq_d  = a_neg ^ b_neg;
            nr_d  = a_neg;
            isr_d = is_rem;
            if (issue_rs2_value_i == '0) begin
                st_d        = DONE;
                div_d.value = is_rem ? issue_rs1_value_i : '1;
            end else if (sgn && issue_rs1_value_i == {1'b1, {(XLEN-1){1'b0}}} && issue_rs2_value_i == '1) begin
                st_d        = DONE;
                div_d.value = is_rem ? '0 : issue_rs1_value_i;
            end else begin
                st_d = CALC;
            end
        end else if (st_q == CALC) begin
            rem_d = r_nx;
            quo_d = q_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN-1)) begin
                st_d        = DONE;
                div_d.value = isr_q ? (nr_q ? -r_nx : r_nx) : (nq_q ? -q_nx : q_nx);
            end
        end else if (st_q == DONE && !stall) begin
            st_d = IDLE;
        end
    end
    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) st_q <= IDLE;
        else st_q <= st_d;
    end
    always_ff @(posedge clock_i) begin
        cnt_q <= cnt_d;
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
        nq_q  <= nq_d;
        nr_q  <= nr_d;
        isr_q <= isr_d;
        div_q <= div_d;
    end
    // Output register: ready gating guarantees mul stage-last and div DONE never collide.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (flush_i) begin
            ex_valid_q <= 1'b0;
        end else if (!stall) begin
            ex_valid_q <= mul_last_v | (st_q == DONE);
            ex_q       <= mul_last_v ? mul_last : div_q;
        end
    end
    assign ex_valid_o   = ex_valid_q;
    assign ex_value_o   = ex_q.value;
    assign ex_rob_tag_o = ex_q.tag;
    assign ex_npc_o     = ex_q.npc;
    assign ex_inst_o    = ex_q.inst;
    assign ex_spec_o    = ex_q.spec;
endmodule
